// File: rtl/wb_i2c_seq_if.sv
// wb_i2c_seq_if: Wishbone link between the transaction sequencer (master)
// and the I2C master core (slave), including the core's interrupt line.
interface wb_i2c_seq_if;
  logic       cyc_o;
  logic       stb_o;
  logic       we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i;
  logic       ack_i;
  logic       irq_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o,
    input  dat_i, ack_i, irq_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o,
    output dat_i, ack_i, irq_i
  );
endinterface

// File: rtl/wb_i2c_seq.sv
// wb_i2c_seq: turns one I2C transaction request into the Wishbone register
// accesses that drive an I2C master core (enable, bus select, START, address,
// data bytes, STOP), streaming write bytes in and read bytes out.
// Optional feature macro WB_SEQ_POLL_EN: when defined, completion of each core
// command is found by polling CMDR; when undefined, the sequencer waits for
// irq_i and reads CMDR once.
module wb_i2c_seq #(
  parameter int WAIT_EN_IRQ = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic         cmd_rd_i,
  input  logic [6:0]   cmd_addr_i,
  input  logic [3:0]   cmd_bus_i,
  input  logic [3:0]   cmd_len_i,
  input  logic         cmd_close_i,
  input  logic [7:0]   wdata_i,
  input  logic         wdata_valid_i,
  output logic         wdata_ready_o,
  output logic [7:0]   rdata_o,
  output logic         rdata_valid_o,
  output logic         rdata_last_o,
  output logic         done_o,
  output logic         err_o,
  output logic [1:0]   err_code_o,
  wb_i2c_seq_if.master wb
);

  localparam logic [1:0] ADR_CSR  = 2'd0;
  localparam logic [1:0] ADR_DPR  = 2'd1;
  localparam logic [1:0] ADR_CMDR = 2'd2;

  localparam logic [7:0] CMD_WRITE     = 8'h01;
  localparam logic [7:0] CMD_READ_ACK  = 8'h02;
  localparam logic [7:0] CMD_READ_NACK = 8'h03;
  localparam logic [7:0] CMD_START     = 8'h04;
  localparam logic [7:0] CMD_STOP      = 8'h05;
  localparam logic [7:0] CMD_SET_BUS   = 8'h06;

  localparam logic [7:0] CSR_VALUE = (WAIT_EN_IRQ != 0) ? 8'hC0 : 8'h80;

  typedef enum logic [3:0] {
    IDLE, ENABLE, SETBUS, START, ADDR, DATA, STOP, WAIT, STATUS, RDDPR, DONE
  } state_t;

  // Remembers which core command the pending status belongs to.
  typedef enum logic [2:0] {
    LC_SETBUS, LC_START, LC_ADDR, LC_DATA, LC_STOP
  } last_t;

  state_t     state, state_n;
  last_t      last_cmd, last_cmd_n;
  logic [1:0] sub, sub_n;
  logic       enabled, enabled_n;
  logic       restart, restart_n;
  logic [3:0] cur_bus, cur_bus_n;
  logic       c_rd, c_rd_n;
  logic [6:0] c_addr, c_addr_n;
  logic [3:0] c_bus, c_bus_n;
  logic       c_close, c_close_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] err_pend, err_pend_n;
  logic [7:0] wbyte, wbyte_n;

  logic       cyc_n, stb_n, we_n;
  logic [1:0] adr_n;
  logic [7:0] dat_n;
  logic       cmd_ready_n, wdata_ready_n;
  logic [7:0] rdata_n;
  logic       rdata_valid_n, rdata_last_n;
  logic       done_n, err_n;
  logic [1:0] err_code_n;

  logic       acc_go, acc_we, acc_done;
  logic [1:0] acc_adr;
  logic [7:0] acc_dat;
  state_t     fin_state;
  logic [7:0] st;

  // Next-state, bus-request and output computation for the sequencer.
  always_comb begin
    state_n       = state;
    last_cmd_n    = last_cmd;
    sub_n         = sub;
    enabled_n     = enabled;
    restart_n     = restart;
    cur_bus_n     = cur_bus;
    c_rd_n        = c_rd;
    c_addr_n      = c_addr;
    c_bus_n       = c_bus;
    c_close_n     = c_close;
    cnt_n         = cnt;
    err_pend_n    = err_pend;
    wbyte_n       = wbyte;
    cyc_n         = wb.cyc_o;
    stb_n         = wb.stb_o;
    we_n          = wb.we_o;
    adr_n         = wb.adr_o;
    dat_n         = wb.dat_o;
    wdata_ready_n = 1'b0;
    rdata_n       = rdata_o;
    rdata_valid_n = 1'b0;
    rdata_last_n  = 1'b0;
    done_n        = 1'b0;
    err_n         = 1'b0;
    err_code_n    = err_code_o;
    acc_go        = 1'b0;
    acc_we        = 1'b0;
    acc_adr       = ADR_CSR;
    acc_dat       = 8'h00;
    acc_done      = wb.cyc_o && wb.ack_i;
    fin_state     = c_close ? DONE : STOP;
    st            = wb.dat_i;

    unique case (state)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          c_rd_n     = cmd_rd_i;
          c_addr_n   = cmd_addr_i;
          c_bus_n    = cmd_bus_i;
          c_close_n  = cmd_close_i;
          cnt_n      = cmd_len_i;
          err_pend_n = 2'd0;
          sub_n      = 2'd0;
          if (!enabled)
            state_n = ENABLE;
          else if (restart && (cmd_bus_i == cur_bus))
            state_n = START;
          else
            state_n = SETBUS;
        end
      end
      ENABLE: begin
        acc_go = 1'b1; acc_we = 1'b1; acc_adr = ADR_CSR; acc_dat = CSR_VALUE;
        if (acc_done) begin
          enabled_n = 1'b1;
          state_n   = SETBUS;
        end
      end
      SETBUS: begin
        acc_go = 1'b1; acc_we = 1'b1;
        if (sub == 2'd0) begin
          acc_adr = ADR_DPR; acc_dat = {4'h0, c_bus};
          if (acc_done) sub_n = 2'd1;
        end else begin
          acc_adr = ADR_CMDR; acc_dat = CMD_SET_BUS;
          if (acc_done) begin
            cur_bus_n  = c_bus;
            last_cmd_n = LC_SETBUS;
            sub_n      = 2'd0;
            state_n    = WAIT;
          end
        end
      end
      START: begin
        acc_go = 1'b1; acc_we = 1'b1; acc_adr = ADR_CMDR; acc_dat = CMD_START;
        if (acc_done) begin
          last_cmd_n = LC_START;
          state_n    = WAIT;
        end
      end
      ADDR: begin
        acc_go = 1'b1; acc_we = 1'b1;
        if (sub == 2'd0) begin
          acc_adr = ADR_DPR; acc_dat = {c_addr, c_rd};
          if (acc_done) sub_n = 2'd1;
        end else begin
          acc_adr = ADR_CMDR; acc_dat = CMD_WRITE;
          if (acc_done) begin
            last_cmd_n = LC_ADDR;
            sub_n      = 2'd0;
            state_n    = WAIT;
          end
        end
      end
      DATA: begin
        if (c_rd) begin
          acc_go = 1'b1; acc_we = 1'b1; acc_adr = ADR_CMDR;
          acc_dat = (cnt == 4'd1) ? CMD_READ_NACK : CMD_READ_ACK;
          if (acc_done) begin
            last_cmd_n = LC_DATA;
            state_n    = WAIT;
          end
        end else begin
          unique case (sub)
            2'd0: begin
              if (wdata_valid_i) begin
                wdata_ready_n = 1'b1;
                sub_n         = 2'd1;
              end
            end
            2'd1: begin
              if (wdata_valid_i) begin
                wbyte_n = wdata_i;
                sub_n   = 2'd2;
              end else begin
                sub_n = 2'd0;
              end
            end
            2'd2: begin
              acc_go = 1'b1; acc_we = 1'b1; acc_adr = ADR_DPR; acc_dat = wbyte;
              if (acc_done) sub_n = 2'd3;
            end
            default: begin
              acc_go = 1'b1; acc_we = 1'b1; acc_adr = ADR_CMDR; acc_dat = CMD_WRITE;
              if (acc_done) begin
                last_cmd_n = LC_DATA;
                sub_n      = 2'd0;
                state_n    = WAIT;
              end
            end
          endcase
        end
      end
      STOP: begin
        acc_go = 1'b1; acc_we = 1'b1; acc_adr = ADR_CMDR; acc_dat = CMD_STOP;
        if (acc_done) begin
          last_cmd_n = LC_STOP;
          state_n    = WAIT;
        end
      end
      WAIT: begin
`ifdef WB_SEQ_POLL_EN
        state_n = STATUS;
`else
        if (wb.irq_i) state_n = STATUS;
`endif
      end
      STATUS: begin
        acc_go = 1'b1; acc_we = 1'b0; acc_adr = ADR_CMDR;
        if (acc_done) begin
          if (st[5]) begin
            err_pend_n = 2'd2;
            state_n    = DONE;
          end else if (st[4] || st[6]) begin
            if (err_pend == 2'd0) err_pend_n = st[4] ? 2'd3 : 2'd1;
            state_n = (last_cmd == LC_STOP) ? DONE : STOP;
          end else if (st[7]) begin
            unique case (last_cmd)
              LC_SETBUS: state_n = START;
              LC_START:  state_n = ADDR;
              LC_ADDR:   state_n = (cnt == 4'd0) ? fin_state : DATA;
              LC_DATA: begin
                if (c_rd) begin
                  state_n = RDDPR;
                end else begin
                  cnt_n   = cnt - 4'd1;
                  state_n = (cnt == 4'd1) ? fin_state : DATA;
                end
              end
              default:   state_n = DONE;
            endcase
          end else begin
            state_n = WAIT;
          end
        end
      end
      RDDPR: begin
        acc_go = 1'b1; acc_we = 1'b0; acc_adr = ADR_DPR;
        if (acc_done) begin
          rdata_n       = wb.dat_i;
          rdata_valid_n = 1'b1;
          rdata_last_n  = (cnt == 4'd1);
          cnt_n         = cnt - 4'd1;
          state_n       = (cnt == 4'd1) ? fin_state : DATA;
        end
      end
      default: begin
        done_n     = 1'b1;
        err_n      = (err_pend != 2'd0);
        err_code_n = err_pend;
        restart_n  = c_close && (err_pend == 2'd0);
        state_n    = IDLE;
      end
    endcase

    if (acc_done) begin
      cyc_n = 1'b0;
      stb_n = 1'b0;
      we_n  = 1'b0;
      adr_n = 2'd0;
      dat_n = 8'h00;
    end else if (acc_go && !wb.cyc_o) begin
      cyc_n = 1'b1;
      stb_n = 1'b1;
      we_n  = acc_we;
      adr_n = acc_adr;
      dat_n = acc_we ? acc_dat : 8'h00;
    end

    cmd_ready_n = (state_n == IDLE);
  end

  // State, captured command and registered outputs; reset aborts any bus cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      last_cmd      <= LC_SETBUS;
      sub           <= 2'd0;
      enabled       <= 1'b0;
      restart       <= 1'b0;
      cur_bus       <= 4'd0;
      c_rd          <= 1'b0;
      c_addr        <= 7'd0;
      c_bus         <= 4'd0;
      c_close       <= 1'b0;
      cnt           <= 4'd0;
      err_pend      <= 2'd0;
      wbyte         <= 8'h00;
      wb.cyc_o      <= 1'b0;
      wb.stb_o      <= 1'b0;
      wb.we_o       <= 1'b0;
      wb.adr_o      <= 2'd0;
      wb.dat_o      <= 8'h00;
      cmd_ready_o   <= 1'b0;
      wdata_ready_o <= 1'b0;
      rdata_o       <= 8'h00;
      rdata_valid_o <= 1'b0;
      rdata_last_o  <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      err_code_o    <= 2'd0;
    end else begin
      state         <= state_n;
      last_cmd      <= last_cmd_n;
      sub           <= sub_n;
      enabled       <= enabled_n;
      restart       <= restart_n;
      cur_bus       <= cur_bus_n;
      c_rd          <= c_rd_n;
      c_addr        <= c_addr_n;
      c_bus         <= c_bus_n;
      c_close       <= c_close_n;
      cnt           <= cnt_n;
      err_pend      <= err_pend_n;
      wbyte         <= wbyte_n;
      wb.cyc_o      <= cyc_n;
      wb.stb_o      <= stb_n;
      wb.we_o       <= we_n;
      wb.adr_o      <= adr_n;
      wb.dat_o      <= dat_n;
      cmd_ready_o   <= cmd_ready_n;
      wdata_ready_o <= wdata_ready_n;
      rdata_o       <= rdata_n;
      rdata_valid_o <= rdata_valid_n;
      rdata_last_o  <= rdata_last_n;
      done_o        <= done_n;
      err_o         <= err_n;
      err_code_o    <= err_code_n;
    end
  end

endmodule

// File: doc/wb_i2c_seq.md
WB_I2C_SEQ -- requirements
Module: wb_i2c_seq

Interface
REQ-001 Parameter WAIT_EN_IRQ, default 1, meaning: 1 enables the core with interrupts (CSR=0xC0), 0 enables it without (CSR=0x80).
REQ-002 clk_i  input  1  system clock; all logic on rising edge.
REQ-003 rst_i  input  1  asynchronous reset, active-low.
REQ-004 cmd_valid_i / cmd_ready_o  in/out  1/1  transaction handshake; accepted when both are high on an edge.
REQ-005 cmd_rd_i  input  1  1=I2C read, 0=I2C write.
REQ-006 cmd_addr_i  input  7  I2C slave address.
REQ-007 cmd_bus_i  input  4  I2C bus id for SET_I2C_BUS.
REQ-008 cmd_len_i  input  4  byte count; 0 means address phase only.
REQ-009 cmd_close_i  input  1  0=STOP after transaction, 1=RESTART (no STOP issued).
REQ-010 wdata_i[7:0], wdata_valid_i, wdata_ready_o  write-byte stream.
REQ-011 rdata_o[7:0], rdata_valid_o (1-cycle pulse), rdata_last_o  read-byte stream.
REQ-012 done_o (1-cycle pulse), err_o (held with done_o), err_code_o[1:0] (0 none, 1 NAK, 2 arbitration lost, 3 core ERR).
REQ-013 cyc_o, stb_o, we_o (1 each), adr_o[1:0], dat_o[7:0], dat_i[7:0], ack_i, irq_i  Wishbone master to the I2C master core.

Function
REQ-014 Register map: CSR=0, DPR=1, CMDR=2, FSMR=3; command codes SET_BUS=0x06, START=0x04, WRITE=0x01, STOP=0x05, READ_ACK=0x02, READ_NACK=0x03.
REQ-015 Each bus access asserts cyc_o/stb_o with stable adr_o/we_o/dat_o until ack_i is sampled high, then deasserts them the following cycle; no back-to-back cycles without one idle cycle.
REQ-016 States: IDLE, ENABLE, SETBUS, START, ADDR, DATA, STOP, WAIT, STATUS, RDDPR, DONE.
REQ-017 cmd_ready_o is high only in IDLE; the command fields are registered on acceptance.
REQ-018 The first command after reset writes CSR once; later commands skip ENABLE.
REQ-019 Sequence: DPR<=bus, CMDR<=SET_BUS; CMDR<=START; DPR<={addr,rd}, CMDR<=WRITE; per byte the data phase; CMDR<=STOP if close=0.
REQ-020 After each CMDR write the FSM enters WAIT, then reads CMDR in STATUS; bit7 DON=ok, bit6 NAK, bit5 AL, bit4 ERR.
REQ-021 Write byte: the FSM waits in DATA for wdata_valid_i, pops with a single-cycle wdata_ready_o, then writes DPR and CMDR<=WRITE.
REQ-022 Read byte: CMDR<=READ_ACK, or READ_NACK for the final byte; after DON it reads DPR and pulses rdata_valid_o with the DPR value, with rdata_last_o set on the final byte.
REQ-023 On NAK or ERR, remaining bytes are skipped, STOP is issued regardless of close, then done_o and err_o assert.
REQ-024 On AL, no STOP is issued; done_o/err_o assert with code 2.
REQ-025 With cmd_len_i=0, only START+address (+STOP) are issued.
REQ-026 With close=1, the next command skips SET_BUS if cmd_bus_i is unchanged and issues START directly (repeated start).
REQ-027 Status bits all zero with DON=0 is not complete; handling is defined by the Configuration section.

Reset
REQ-028 On rst_i low, asynchronously: state=IDLE, cyc_o=stb_o=we_o=0, adr_o=0, dat_o=0, cmd_ready_o=0 until the first edge after release, wdata_ready_o=0, rdata_valid_o=0, rdata_last_o=0, done_o=0, err_o=0, err_code_o=0, the enabled flag clears, and the restart flag clears.
REQ-029 Reset mid-bus-cycle drops cyc_o/stb_o immediately; no transaction is resumed.

Configuration
REQ-030 WB_SEQ_POLL_EN defined: WAIT performs repeated CMDR reads (one idle cycle apart) until DON/NAK/AL/ERR is set; irq_i is ignored.
REQ-031 WB_SEQ_POLL_EN undefined: WAIT idles until irq_i is high, then does a single CMDR read in STATUS, which clears irq.

Verification
REQ-032 Write of 2 bytes to addr 0x22 on bus 5 with close=0, data 0xA5, 0x3C -> WB writes CSR=0xC0, DPR=05, CMDR=06, CMDR=04, DPR=0x44, CMDR=01, DPR=A5, CMDR=01, DPR=3C, CMDR=01, CMDR=05; one done_o pulse with err_o=0.
REQ-033 Read of 3 bytes from 0x22 with the core returning 0x11, 0x22, 0x33 -> DPR=0x45, CMDR 02, 02, 03, and rdata pulses 11, 22, 33 with rdata_last_o on 33.
REQ-034 Address phase returns NAK (CMDR status 0x40) -> no data phase, CMDR=05 issued, done_o with err_code_o=1.
REQ-035 Write with close=1 followed by a read on the same bus -> second command begins with CMDR=04 and has no SET_BUS or CSR write.
REQ-036 rst_i asserted while stb_o is high during the DATA phase -> cyc_o/stb_o are 0 in the same cycle; the next command re-issues the CSR write.
